// File: rtl/conv1d_job_sequencer.sv
// conv1d_job_sequencer: runs one 1-D convolution job on the systolic datapath.
// It checks the job config, pulses the datapath clear, and streams the kernel taps.
// It then streams the samples and counts results until done or a drain timeout.
// The host-side valid/ready streams are converted into the datapath's one-cycle load/valid strobes.
module conv1d_job_sequencer #(
    parameter int NUM_PE        = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int LEN_WIDTH     = 16,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4:0]            cfg_taps,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg,
    output logic                  err_timeout,
    input  logic                  k_valid,
    output logic                  k_ready,
    input  logic [DATA_WIDTH-1:0] k_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  conv_clear,
    output logic [4:0]            conv_active_pe_count,
    output logic                  conv_kernel_load,
    output logic [DATA_WIDTH-1:0] conv_kernel_value,
    output logic [DATA_WIDTH-1:0] conv_x_in,
    output logic                  conv_x_valid,
    input  logic [DATA_WIDTH-1:0] conv_y_out,
    input  logic                  conv_y_valid,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LEN_WIDTH-1:0]  out_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD_K = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [2:0]            state_q, state_d;
    logic [4:0]            taps_q, taps_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [4:0]            kcnt_q, kcnt_d;
    logic [LEN_WIDTH-1:0]  scnt_q, scnt_d;
    logic [LEN_WIDTH-1:0]  out_count_q, out_count_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  done_q, done_d;
    logic                  err_cfg_q, err_cfg_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  kload_q, kload_d;
    logic [DATA_WIDTH-1:0] kval_q, kval_d;
    logic                  xval_q, xval_d;
    logic [DATA_WIDTH-1:0] xin_q, xin_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    logic                  k_hs;
    logic                  s_hs;
    logic                  cfg_bad;
    logic                  job_complete;
    logic [LEN_WIDTH-1:0]  target;

    assign busy    = (state_q != S_IDLE);
    assign k_ready = (state_q == S_LOAD_K);
    assign s_ready = (state_q == S_STREAM);
    assign k_hs    = k_valid && k_ready;
    assign s_hs    = s_valid && s_ready;

    // Illegal: no taps, more taps than PEs, or fewer samples than taps.
    assign cfg_bad = (cfg_taps == 5'd0) || (int'(cfg_taps) > NUM_PE) ||
                     (cfg_len < LEN_WIDTH'(cfg_taps));

    // A valid convolution of len samples with taps coefficients yields len-taps+1 outputs.
    assign target       = len_q - LEN_WIDTH'(taps_q) + LEN_WIDTH'(1);
    assign job_complete = (out_count_q == target);

    assign done                 = done_q;
    assign err_cfg              = err_cfg_q;
    assign err_timeout          = err_timeout_q;
    assign conv_clear           = (state_q == S_CLEAR);
    assign conv_active_pe_count = taps_q;
    assign conv_kernel_load     = kload_q;
    assign conv_kernel_value    = kval_q;
    assign conv_x_in            = xin_q;
    assign conv_x_valid         = xval_q;
    assign m_valid              = m_valid_q;
    assign m_data               = m_data_q;
    assign out_count            = out_count_q;

    // Next-state logic for the job FSM, stream-to-strobe conversion and result counting.
    always_comb begin
        state_d       = state_q;
        taps_d        = taps_q;
        len_d         = len_q;
        kcnt_d        = kcnt_q;
        scnt_d        = scnt_q;
        out_count_d   = out_count_q;
        idle_d        = idle_q;
        done_d        = 1'b0;
        err_cfg_d     = 1'b0;
        err_timeout_d = 1'b0;
        kload_d       = k_hs;
        kval_d        = k_hs ? k_data : kval_q;
        xval_d        = s_hs;
        xin_d         = s_hs ? s_data : xin_q;
        m_valid_d     = conv_y_valid;
        m_data_d      = conv_y_out;

        // Results arriving while idle are forwarded but belong to no job.
        if (conv_y_valid && busy && (out_count_q != '1)) begin
            out_count_d = out_count_q + LEN_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_cfg_d = 1'b1;
                    end else begin
                        taps_d      = cfg_taps;
                        len_d       = cfg_len;
                        out_count_d = '0;
                        state_d     = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                kcnt_d  = '0;
                scnt_d  = '0;
                idle_d  = '0;
                state_d = S_LOAD_K;
            end
            S_LOAD_K: begin
                if (k_hs) begin
                    kcnt_d = kcnt_q + 5'd1;
                    if ((kcnt_q + 5'd1) == taps_q) begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (job_complete) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (s_hs) begin
                    scnt_d = scnt_q + LEN_WIDTH'(1);
                    if ((scnt_q + LEN_WIDTH'(1)) == len_q) begin
                        idle_d  = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (job_complete) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (conv_y_valid) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(DRAIN_TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any job silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            taps_q        <= '0;
            len_q         <= '0;
            kcnt_q        <= '0;
            scnt_q        <= '0;
            out_count_q   <= '0;
            idle_q        <= '0;
            done_q        <= 1'b0;
            err_cfg_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            kload_q       <= 1'b0;
            kval_q        <= '0;
            xval_q        <= 1'b0;
            xin_q         <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
        end else begin
            state_q       <= state_d;
            taps_q        <= taps_d;
            len_q         <= len_d;
            kcnt_q        <= kcnt_d;
            scnt_q        <= scnt_d;
            out_count_q   <= out_count_d;
            idle_q        <= idle_d;
            done_q        <= done_d;
            err_cfg_q     <= err_cfg_d;
            err_timeout_q <= err_timeout_d;
            kload_q       <= kload_d;
            kval_q        <= kval_d;
            xval_q        <= xval_d;
            xin_q         <= xin_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
        end
    end

endmodule

// File: tb/tb_conv1d_job_sequencer.sv
// Directed bench for conv1d_job_sequencer with a behavioural systolic datapath model.
module tb_conv1d_job_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [4:0]  cfg_taps;
    logic [15:0] cfg_len;
    logic        busy, done, err_cfg, err_timeout;
    logic        k_valid, k_ready, s_valid, s_ready;
    logic [7:0]  k_data, s_data;
    logic        conv_clear;
    logic [4:0]  conv_active_pe_count;
    logic        conv_kernel_load;
    logic [7:0]  conv_kernel_value, conv_x_in;
    logic        conv_x_valid;
    logic [7:0]  conv_y_out;
    logic        conv_y_valid;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [15:0] out_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] k_arr [0:31];
    logic [7:0] s_arr [0:63];

    // datapath model state
    logic       model_en = 1'b1;
    logic       y_inj    = 1'b0;
    logic [7:0] mk   [0:15];
    logic [7:0] hist [0:15];
    logic [4:0] mk_idx;
    int         ms_cnt;

    // monitor counters
    int n_kload = 0, n_xv = 0, n_xv_b2b = 0, n_res = 0;
    int n_done = 0, n_errc = 0, n_errt = 0, n_clr = 0;
    logic prev_xv = 1'b0;
    logic [7:0] res_q [$];

    conv1d_job_sequencer #(
        .NUM_PE(16), .DATA_WIDTH(8), .LEN_WIDTH(16), .DRAIN_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_taps(cfg_taps), .cfg_len(cfg_len),
        .busy(busy), .done(done), .err_cfg(err_cfg), .err_timeout(err_timeout),
        .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .conv_clear(conv_clear), .conv_active_pe_count(conv_active_pe_count),
        .conv_kernel_load(conv_kernel_load), .conv_kernel_value(conv_kernel_value),
        .conv_x_in(conv_x_in), .conv_x_valid(conv_x_valid),
        .conv_y_out(conv_y_out), .conv_y_valid(conv_y_valid),
        .m_valid(m_valid), .m_data(m_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] win_sum(input logic [7:0] x);
        int acc;
        int t;
        int idx;
        acc = 0;
        t = int'(conv_active_pe_count);
        for (int j = 0; j < 16; j++) begin
            if (j < t) begin
                idx = t - 1 - j;
                acc += int'(mk[j]) * ((idx == 0) ? int'(x) : int'(hist[idx-1]));
            end
        end
        return acc[7:0];
    endfunction

    // Datapath: kernel loads fill taps in order; each full window yields one result a cycle later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mk_idx       <= '0;
            ms_cnt       <= 0;
            conv_y_valid <= 1'b0;
            conv_y_out   <= '0;
        end else begin
            conv_y_valid <= 1'b0;
            if (conv_clear) begin
                mk_idx <= '0;
                ms_cnt <= 0;
            end else begin
                if (conv_kernel_load) begin
                    mk[mk_idx[3:0]] <= conv_kernel_value;
                    mk_idx <= mk_idx + 5'd1;
                end
                if (conv_x_valid) begin
                    hist[0] <= conv_x_in;
                    for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
                    ms_cnt <= ms_cnt + 1;
                    if (model_en && (ms_cnt + 1 >= int'(conv_active_pe_count))) begin
                        conv_y_valid <= 1'b1;
                        conv_y_out   <= win_sum(conv_x_in);
                    end
                end
            end
            if (y_inj) begin
                conv_y_valid <= 1'b1;
                conv_y_out   <= 8'h5A;
            end
        end
    end

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (conv_kernel_load) n_kload <= n_kload + 1;
        if (conv_x_valid) n_xv <= n_xv + 1;
        if (conv_x_valid && prev_xv) n_xv_b2b <= n_xv_b2b + 1;
        prev_xv <= conv_x_valid;
        if (m_valid) begin
            n_res <= n_res + 1;
            res_q.push_back(m_data);
        end
        if (done) n_done <= n_done + 1;
        if (err_cfg) n_errc <= n_errc + 1;
        if (err_timeout) n_errt <= n_errt + 1;
        if (conv_clear) n_clr <= n_clr + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] outs_vec();
        return {9'd0, busy, done, err_cfg, err_timeout, k_ready, s_ready, conv_clear,
                conv_kernel_load, conv_x_valid, m_valid, conv_active_pe_count,
                conv_kernel_value, conv_x_in, m_data, out_count};
    endfunction

    function automatic logic [7:0] res_at(input int i);
        if (i < res_q.size()) return res_q[i];
        return 8'hxx;
    endfunction

    task automatic do_start(input logic [4:0] t, input logic [15:0] l);
        @(negedge clk);
        start = 1'b1; cfg_taps = t; cfg_len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives both streams every cycle (optionally every other cycle) until stop_after samples are taken.
    task automatic drive_job(input int len, input bit bubble, input int stop_after,
                             input int inj_at, output bit ok);
        int kidx;
        int sidx;
        bit ph;
        bit hk;
        bit hs;
        kidx = 0; sidx = 0; ph = 1'b1; ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == inj_at) begin
                start = 1'b1; cfg_taps = 5'd2; cfg_len = 16'd3;
            end
            if (c == inj_at + 1) start = 1'b0;
            k_valid = ph;
            k_data  = k_arr[kidx];
            s_valid = ph && (sidx < len);
            s_data  = s_arr[sidx];
            hk = k_valid && k_ready;
            hs = s_valid && s_ready;
            @(posedge clk);
            if (hk && kidx < 31) kidx++;
            if (hs) sidx++;
            if (bubble) ph = !ph;
            if (sidx == stop_after) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            k_valid = 1'b0; s_valid = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_basic_vectors();
        for (int i = 0; i < 32; i++) k_arr[i] = 8'd9;
        k_arr[0] = 8'd1; k_arr[1] = 8'd2; k_arr[2] = 8'd1;
        for (int i = 0; i < 64; i++) s_arr[i] = 8'(i + 1);
    endtask

    task automatic test_reset();
        logic [63:0] ov;
        repeat (3) @(negedge clk);
        ov = outs_vec();
        n_checks++;
        if (ov !== 64'd0) $display("FAIL reset_outputs: got %h expected 0", ov);
        else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, conv_clear, k_ready, s_ready} !== 4'b0000)
            $display("FAIL reset_idle: got busy/clr/kr/sr=%b expected 0000",
                     {busy, conv_clear, k_ready, s_ready});
        else n_pass++;
    endtask

    task automatic test_basic();
        int bk, bx, br, bd, rb;
        bit ok, seen;
        logic [7:0] exp_r [0:3];
        exp_r[0] = 8'd8; exp_r[1] = 8'd12; exp_r[2] = 8'd16; exp_r[3] = 8'd20;
        load_basic_vectors();
        bk = n_kload; bx = n_xv; br = n_res; bd = n_done; rb = res_q.size();
        do_start(5'd3, 16'd6);
        n_checks++;
        if (busy !== 1'b1 || conv_clear !== 1'b1)
            $display("FAIL basic_clear: got busy=%b clear=%b expected 1 1", busy, conv_clear);
        else n_pass++;
        drive_job(6, 1'b0, 6, -1, ok);
        wait_done(200, seen);
        repeat (3) @(negedge clk);
        n_checks++;
        if (!(ok && seen)) $display("FAIL basic_done_seen: got stream=%0b done=%0b expected 1 1", ok, seen);
        else n_pass++;
        n_checks++;
        if (n_kload - bk !== 3) $display("FAIL basic_kload: got %0d expected 3", n_kload - bk);
        else n_pass++;
        n_checks++;
        if (n_xv - bx !== 6) $display("FAIL basic_xvalid: got %0d expected 6", n_xv - bx);
        else n_pass++;
        n_checks++;
        if (n_res - br !== 4) $display("FAIL basic_results: got %0d expected 4", n_res - br);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (res_at(rb + i) !== exp_r[i])
                $display("FAIL basic_mdata%0d: got %0d expected %0d", i, res_at(rb + i), exp_r[i]);
            else n_pass++;
        end
        n_checks++;
        if (out_count !== 16'd4) $display("FAIL basic_out_count: got %0d expected 4", out_count);
        else n_pass++;
        n_checks++;
        if (n_done - bd !== 1 || busy !== 1'b0)
            $display("FAIL basic_done_pulse: got pulses=%0d busy=%b expected 1 0", n_done - bd, busy);
        else n_pass++;
    endtask

    task automatic test_idle_forward();
        @(negedge clk);
        y_inj = 1'b1;
        @(negedge clk);
        y_inj = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h5A)
            $display("FAIL idle_forward: got m_valid=%b m_data=%h expected 1 5a", m_valid, m_data);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_count !== 16'd4) $display("FAIL idle_not_counted: got %0d expected 4", out_count);
        else n_pass++;
    endtask

    task automatic test_bad_cfg();
        logic [4:0]  tt [0:2];
        logic [15:0] ll [0:2];
        int be;
        tt[0] = 5'd0;  ll[0] = 16'd8;
        tt[1] = 5'd17; ll[1] = 16'd8;
        tt[2] = 5'd5;  ll[2] = 16'd4;
        be = n_errc;
        for (int i = 0; i < 3; i++) begin
            do_start(tt[i], ll[i]);
            n_checks++;
            if (err_cfg !== 1'b1 || busy !== 1'b0)
                $display("FAIL badcfg%0d_pulse: got err_cfg=%b busy=%b expected 1 0", i, err_cfg, busy);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (err_cfg !== 1'b0 || busy !== 1'b0)
                $display("FAIL badcfg%0d_after: got err_cfg=%b busy=%b expected 0 0", i, err_cfg, busy);
            else n_pass++;
        end
        n_checks++;
        if (n_errc - be !== 3) $display("FAIL badcfg_count: got %0d expected 3", n_errc - be);
        else n_pass++;
    endtask

    task automatic test_bubbles();
        int bk, bx, bb, br, bd, rb;
        bit ok, seen;
        for (int i = 0; i < 32; i++) k_arr[i] = 8'd1;
        for (int i = 0; i < 64; i++) s_arr[i] = 8'(i + 1);
        bk = n_kload; bx = n_xv; bb = n_xv_b2b; br = n_res; bd = n_done; rb = res_q.size();
        do_start(5'd16, 16'd16);
        drive_job(16, 1'b1, 16, -1, ok);
        wait_done(200, seen);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_kload - bk !== 16) $display("FAIL bubble_kload: got %0d expected 16", n_kload - bk);
        else n_pass++;
        n_checks++;
        if (n_xv - bx !== 16 || n_xv_b2b - bb !== 0)
            $display("FAIL bubble_xvalid: got count=%0d b2b=%0d expected 16 0", n_xv - bx, n_xv_b2b - bb);
        else n_pass++;
        n_checks++;
        if (n_res - br !== 1 || res_at(rb) !== 8'd136)
            $display("FAIL bubble_result: got n=%0d data=%0d expected 1 136", n_res - br, res_at(rb));
        else n_pass++;
        n_checks++;
        if (!seen || n_done - bd !== 1 || out_count !== 16'd1)
            $display("FAIL bubble_done: got pulses=%0d out_count=%0d expected 1 1", n_done - bd, out_count);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int bd, bt, br, k;
        bit ok;
        load_basic_vectors();
        model_en = 1'b0;
        bd = n_done; bt = n_errt; br = n_res;
        do_start(5'd2, 16'd8);
        drive_job(8, 1'b0, 8, -1, ok);
        k = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k_valid = 1'b0; s_valid = 1'b0;
            if (err_timeout) begin
                k = i;
                break;
            end
        end
        repeat (3) @(negedge clk);
        model_en = 1'b1;
        n_checks++;
        if (!ok || k !== 64) $display("FAIL timeout_latency: got %0d expected 64", k);
        else n_pass++;
        n_checks++;
        if (n_errt - bt !== 1 || n_done - bd !== 0)
            $display("FAIL timeout_pulses: got err=%0d done=%0d expected 1 0", n_errt - bt, n_done - bd);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || n_res - br !== 0)
            $display("FAIL timeout_idle: got busy=%b results=%0d expected 0 0", busy, n_res - br);
        else n_pass++;
    endtask

    task automatic test_reset_mid_job();
        int bd, be, bc, br, rb;
        bit ok, seen;
        logic [63:0] ov;
        load_basic_vectors();
        bd = n_done; be = n_errc + n_errt;
        do_start(5'd3, 16'd6);
        drive_job(6, 1'b0, 3, -1, ok);
        @(negedge clk);
        k_valid = 1'b0; s_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        ov = outs_vec();
        n_checks++;
        if (!ok || ov !== 64'd0) $display("FAIL midreset_outputs: got %h expected 0", ov);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (n_done - bd !== 0 || (n_errc + n_errt) - be !== 0 || busy !== 1'b0)
            $display("FAIL midreset_silent: got done=%0d err=%0d busy=%b expected 0 0 0",
                     n_done - bd, (n_errc + n_errt) - be, busy);
        else n_pass++;
        bc = n_clr; br = n_res; bd = n_done; rb = res_q.size();
        do_start(5'd3, 16'd6);
        drive_job(6, 1'b0, 6, -1, ok);
        wait_done(200, seen);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_clr - bc !== 1) $display("FAIL midreset_clear: got %0d expected 1", n_clr - bc);
        else n_pass++;
        n_checks++;
        if (n_res - br !== 4 || res_at(rb) !== 8'd8 || res_at(rb + 3) !== 8'd20)
            $display("FAIL midreset_results: got n=%0d first=%0d last=%0d expected 4 8 20",
                     n_res - br, res_at(rb), res_at(rb + 3));
        else n_pass++;
        n_checks++;
        if (!seen || n_done - bd !== 1) $display("FAIL midreset_done: got %0d expected 1", n_done - bd);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int bk, br, bd, be, rb;
        bit ok, seen;
        load_basic_vectors();
        bk = n_kload; br = n_res; bd = n_done; be = n_errc; rb = res_q.size();
        do_start(5'd3, 16'd6);
        drive_job(6, 1'b0, 6, 1, ok);
        wait_done(200, seen);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_kload - bk !== 3) $display("FAIL busystart_kload: got %0d expected 3", n_kload - bk);
        else n_pass++;
        n_checks++;
        if (n_res - br !== 4 || res_at(rb + 1) !== 8'd12 || res_at(rb + 3) !== 8'd20)
            $display("FAIL busystart_results: got n=%0d r1=%0d r3=%0d expected 4 12 20",
                     n_res - br, res_at(rb + 1), res_at(rb + 3));
        else n_pass++;
        n_checks++;
        if (!seen || n_done - bd !== 1 || n_errc - be !== 0)
            $display("FAIL busystart_done: got done=%0d err_cfg=%0d expected 1 0", n_done - bd, n_errc - be);
        else n_pass++;
        n_checks++;
        if (conv_active_pe_count !== 5'd3 || out_count !== 16'd4)
            $display("FAIL busystart_cfg: got taps=%0d out_count=%0d expected 3 4",
                     conv_active_pe_count, out_count);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; cfg_taps = '0; cfg_len = '0;
        k_valid = 1'b0; s_valid = 1'b0; k_data = '0; s_data = '0;
        test_reset();
        test_basic();
        test_idle_forward();
        test_bad_cfg();
        test_bubbles();
        test_timeout();
        test_reset_mid_job();
        test_start_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
